slice_serial_adder: RTL
=======================

// Module: slice_serial_adder
//
// PURPOSE
//   Multi-cycle wide adder that drives one nBitCarryLookAheadAdder slice (NUMBITS wide).
//   It adds two NUMBITS*NUMSLICES-bit operands, one slice per clock, least-significant slice first.
//   The carry is registered between slices.
//   It sits directly upstream of the CLA slice: it feeds a_in/b_in/c_in and consumes s_out/c_out.
//   It then presents the full-width sum behind a start/done handshake.
//
// PARAMETERS
//   NUMBITS    4  width of the CLA slice instance, in bits
//   NUMSLICES  4  slices per operand; W = NUMBITS*NUMSLICES (default 16)
//
// PORTS
//   clk     in   1  clock, rising edge
//   reset   in   1  asynchronous, active-high reset
//   start   in   1  request; sampled on rising clk edge
//   a_in    in   W  operand A; captured on the accepted start edge
//   b_in    in   W  operand B; captured on the accepted start edge
//   c_in    in   1  carry-in to slice 0; captured on the accepted start edge
//   busy    out  1  high while slices are being added
//   done    out  1  one-cycle pulse; s_out/c_out hold the new result
//   s_out   out  W  sum register
//   c_out   out  1  carry-out of the most-significant slice
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy, done, s_out, c_out all 0.
//     Reset also clears the working registers and the slice index.
//   - FSM states:
//     - IDLE: start=1 -> RUN. Latch a_in, b_in and c_in; idx=0; clear the working sum.
//     - RUN, each edge:
//       - work[idx] = slice sum of a[idx], b[idx] and carry_reg.
//       - carry_reg is updated with the slice c_out.
//       - idx increments.
//       - On the edge that processes idx=NUMSLICES-1: s_out<=work (with the final slice) and
//         c_out<=final carry, then -> DONE.
//     - DONE: done=1 for exactly this one cycle, then -> IDLE.
//       If start=1 in DONE, the request is accepted exactly as in IDLE (back-to-back, no idle gap).
//   - Latency: start is accepted at edge E0. done is high in the cycle after edge E0+NUMSLICES.
//     Throughput is one result per NUMSLICES+1 cycles.
//   - busy=1 exactly while in RUN (NUMSLICES cycles). start while busy is ignored.
//     Operands changing during RUN have no effect.
//   - s_out/c_out change only on the completing edge. They hold the previous result at all other times.
//   - Arithmetic: {c_out,s_out} = a + b + c_in, taken modulo 2^(W+1).
//     No overflow flag; unsigned semantics.
//   - Slice selection: the slice at index idx is bits [idx*NUMBITS +: NUMBITS].
//     idx counter width is clog2(NUMSLICES) (minimum 1 bit); it wraps only via the FSM reset to 0.
//   - Reset mid-RUN aborts the operation: no done pulse; s_out and c_out return to 0.
//   - Reset and start on the same edge: reset wins.
//   - NUMSLICES=1: single RUN cycle; behaviour is otherwise identical.
//
// TESTING (NUMBITS=4, NUMSLICES=4)
//   1. Assert reset with clk idle -> busy=0, done=0, s_out=16'h0000, c_out=0, with no clock edge needed.
//   2. a=16'h00FF, b=16'h0001, c_in=0, one-cycle start -> busy for 4 cycles;
//      done on the 5th cycle after start; s_out=16'h0100, c_out=0.
//   3. a=16'hFFFF, b=16'h0000, c_in=1 -> carry ripples through all slices; s_out=16'h0000, c_out=1.
//   4. Start op (1234+1111); re-assert start with a=FFFF, b=FFFF in RUN cycle 2
//      -> single done, s_out=16'h2345, c_out=0. The second request is dropped.
//   5. Reset pulse during RUN cycle 2 of op (FFFF+0001) -> no done, outputs 0.
//      A following op (0005+0003) gives s_out=16'h0008.
//   6. start held high continuously with 1000 random operands -> done every 5 cycles.
//      Each {c_out,s_out} must equal a+b+c_in. Count tests run and errors, and log them.

Source files
------------

// File: rtl/slice_serial_adder.sv
// slice_serial_adder: adds two NUMBITS*NUMSLICES-bit operands one NUMBITS-wide
// carry-lookahead slice per clock, least-significant slice first, with the
// carry registered between slices.
//
// Handshake: start is a request sampled on the rising edge. It is accepted
// only when the block is IDLE or DONE (never while busy). The accepting edge
// captures a_in/b_in/c_in. done is a one-cycle pulse; s_out/c_out hold the
// new result from that pulse until the next completion.
//
// State encoding, visible on state_dbg: IDLE=0, RUN=1, DONE=2.
module slice_serial_adder #(
    parameter int NUMBITS   = 4,
    parameter int NUMSLICES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUMBITS*NUMSLICES-1:0]   a_in,
    input  logic [NUMBITS*NUMSLICES-1:0]   b_in,
    input  logic                           c_in,
    output logic                           busy,
    output logic                           done,
    output logic [NUMBITS*NUMSLICES-1:0]   s_out,
    output logic                           c_out,
    output logic [1:0]                     state_dbg
);

    localparam int W    = NUMBITS * NUMSLICES;
    localparam int IDXW = (NUMSLICES > 1) ? $clog2(NUMSLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUMSLICES - 1);
    localparam logic [W-1:0]    SLICE_MASK = W'({NUMBITS{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]       a_reg, b_reg, work, work_next;
    logic               carry_reg;
    logic [IDXW-1:0]    idx;
    logic [31:0]        sh;
    logic [NUMBITS-1:0] sl_a, sl_b, sl_s;
    logic               sl_c;
    logic               accept, last_slice;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_slice = (state == RUN) && (idx == LAST_IDX);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign state_dbg  = state;

    // Select the current slice of each captured operand.
    always_comb begin
        sh   = 32'(idx) * 32'(NUMBITS);
        sl_a = NUMBITS'(a_reg >> sh);
        sl_b = NUMBITS'(b_reg >> sh);
    end

    // Carry-lookahead slice: generate/propagate with the registered carry-in.
    always_comb begin
        logic [NUMBITS-1:0] g, p;
        logic [NUMBITS:0]   cy;
        g     = sl_a & sl_b;
        p     = sl_a ^ sl_b;
        cy    = '0;
        cy[0] = carry_reg;
        for (int i = 0; i < NUMBITS; i++) begin
            cy[i+1] = g[i] | (p[i] & cy[i]);
        end
        sl_s = p ^ cy[NUMBITS-1:0];
        sl_c = cy[NUMBITS];
    end

    // Merge the slice sum into its position of the working sum.
    always_comb begin
        work_next = (work & ~(SLICE_MASK << sh)) | (W'(sl_s) << sh);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new request exactly like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and result update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            work      <= '0;
            idx       <= '0;
            s_out     <= '0;
            c_out     <= 1'b0;
        end else if (accept) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= c_in;
            work      <= '0;
            idx       <= '0;
        end else if (state == RUN) begin
            work      <= work_next;
            carry_reg <= sl_c;
            idx       <= last_slice ? '0 : idx + 1'b1;
            if (last_slice) begin
                s_out <= work_next;
                c_out <= sl_c;
            end
        end
    end

endmodule
